lab1_imul_int_div_iter: RTL and testbench

LAB1_IMUL_INT_DIV_ITER -- requirements
Module: lab1_imul_int_div_iter

---
 rtl/lab1_imul_int_div_iter.sv | 180 ++++++++++++++++++
 tb/tb_lab1_imul_int_div_iter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_imul_int_div_iter.sv
// lab1_imul_int_div_iter
// Iterative 32-bit restoring divider behind val/rdy request/response ports.
// A request carries {dividend, divisor}. The response carries {remainder, quotient}.
// The FSM moves through IDLE -> CALC -> DONE. CALC always takes 32 cycles, one
// quotient bit per cycle, and never exits early.
//
// Optional feature macro: LAB1_IMUL_INT_DIV_SIGNED_EN
//   - undefined (default): operands and results are unsigned.
//   - defined: operands are two's complement. The divider works on magnitudes,
//     and the signs are fixed up on the final CALC step, so no cycles are added.
//     The result truncates toward zero.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// req_rdy and resp_val are decoded from the state register only.
// req_rdy is also forced low while reset is high.
module lab1_imul_int_div_iter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_val,
   output logic        req_rdy,
   input  logic [63:0] req_msg,
   output logic        resp_val,
   input  logic        resp_rdy,
   output logic [63:0] resp_msg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  cnt;   // iteration counter, 0..31 within CALC
   logic [31:0] rem;   // partial remainder
   logic [31:0] quo;   // holds dividend bits, then quotient bits shift in from the right
   logic [31:0] dvs;   // latched divisor (magnitude in signed build)

   logic        req_go;
   logic        resp_go;
   logic        last_step;

   // Operand and result values as presented to the datapath.
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [31:0] load_a;
   logic [31:0] load_b;

   // One restoring-division step.
   logic [32:0] shifted;
   logic [32:0] diff;
   logic        q_bit;
   logic [31:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] rem_final;
   logic [31:0] quo_final;

`ifdef LAB1_IMUL_INT_DIV_SIGNED_EN
   logic        neg_q;     // quotient must be negated (operand signs differ)
   logic        neg_r;     // remainder must be negated (dividend negative)
   logic        div_zero;  // divide-by-zero keeps the all-ones quotient unnegated
`endif

   assign req_go    = req_val  && req_rdy;
   assign resp_go   = resp_val && resp_rdy;
   assign last_step = (state == CALC) && (cnt == 5'd31);

   assign req_a = req_msg[63:32];
   assign req_b = req_msg[31:0];

   assign req_rdy  = (state == IDLE) && !reset;
   assign resp_val = (state == DONE);
   assign resp_msg = {rem, quo};

`ifdef LAB1_IMUL_INT_DIV_SIGNED_EN
   // Take magnitudes of the incoming operands. |0x80000000| is 0x80000000, which is still correct as unsigned.
   always_comb begin
      load_a = req_a[31] ? (32'd0 - req_a) : req_a;
      load_b = req_b[31] ? (32'd0 - req_b) : req_b;
   end
`else
   // In the unsigned build the operands go straight in.
   always_comb begin
      load_a = req_a;
      load_b = req_b;
   end
`endif

   // Shift {rem, quo} left by one, then subtract the divisor if it fits (33-bit compare).
   always_comb begin
      shifted  = {rem, quo[31]};
      diff     = shifted - {1'b0, dvs};
      q_bit    = (shifted >= {1'b0, dvs});
      rem_next = q_bit ? diff[31:0] : shifted[31:0];
      quo_next = {quo[30:0], q_bit};
   end

`ifdef LAB1_IMUL_INT_DIV_SIGNED_EN
   // Sign fix-up of the final step.
   // With a zero divisor, the quotient stays all-ones and the remainder gets back the original dividend.
   always_comb begin
      quo_final = (neg_q && !div_zero) ? (32'd0 - quo_next) : quo_next;
      rem_final = neg_r ? (32'd0 - rem_next) : rem_next;
   end
`else
   // No fix-up is needed in the unsigned build.
   always_comb begin
      quo_final = quo_next;
      rem_final = rem_next;
   end
`endif

   // Control FSM: state and iteration counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_go) begin
                  state <= CALC;
                  cnt   <= 5'd0;
               end
            end
            CALC: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (resp_go) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 5'd0;
            end
         endcase
      end
   end

   // Datapath: load on acceptance, step in CALC, hold otherwise.
   // Holding keeps resp_msg stable under back-pressure.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem <= 32'd0;
         quo <= 32'd0;
         dvs <= 32'd0;
      end else if (req_go) begin
         rem <= 32'd0;
         quo <= load_a;
         dvs <= load_b;
      end else if (last_step) begin
         rem <= rem_final;
         quo <= quo_final;
      end else if (state == CALC) begin
         rem <= rem_next;
         quo <= quo_next;
      end
   end

`ifdef LAB1_IMUL_INT_DIV_SIGNED_EN
   // Sign flags are captured with the operands and used on the last step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
      end else if (req_go) begin
         neg_q    <= req_a[31] ^ req_b[31];
         neg_r    <= req_a[31];
         div_zero <= (req_b == 32'd0);
      end
   end
`endif

endmodule

// File: tb/tb_lab1_imul_int_div_iter.sv
// Testbench for lab1_imul_int_div_iter.
// Directed scenarios and a randomized run are each checked against a plain-arithmetic
// reference model. The model follows LAB1_IMUL_INT_DIV_SIGNED_EN when it is defined.
module tb_lab1_imul_int_div_iter;

   logic        clk;
   logic        reset;
   logic        req_val;
   logic        req_rdy;
   logic [63:0] req_msg;
   logic        resp_val;
   logic        resp_rdy;
   logic [63:0] resp_msg;

   int n_checks = 0;
   int n_errors = 0;

   lab1_imul_int_div_iter dut (
      .clk      (clk),
      .reset    (reset),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_msg  (req_msg),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .resp_msg (resp_msg)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: returns {remainder, quotient}
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
`ifdef LAB1_IMUL_INT_DIV_SIGNED_EN
      longint sa;
      longint sb;
      longint sq;
      longint sr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         sq = sa / sb;
         sr = sa % sb;
         q  = sq[31:0];
         r  = sr[31:0];
      end
`else
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
`endif
      return {r, q};
   endfunction

   // Driver: called at a negedge. Returns at the negedge after the accepting edge.
   task automatic send_req(input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      req_val = 1'b1;
      req_msg = {a, b};
      while (!req_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (!req_rdy) begin
         n_errors++;
         $display("FAIL send_req_timeout: req_rdy=%0b expected 1 within 100 cycles", req_rdy);
      end else begin
         @(posedge clk);
      end
      @(negedge clk);
      req_val = 1'b0;
      req_msg = {$urandom, $urandom};  // must not affect the in-flight result
   endtask

   // Driver: waits for resp_val, holds resp_rdy low for 'hold' cycles, then accepts.
   // lat counts negedges from the call.
   task automatic wait_resp(input int hold, output logic [63:0] msg, output int lat);
      lat = 0;
      resp_rdy = 1'b0;
      while (!resp_val && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      msg = resp_msg;
      if (resp_val) begin
         repeat (hold) @(negedge clk);
         resp_rdy = 1'b1;
         @(posedge clk);
         @(negedge clk);
         resp_rdy = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      req_val  = 1'b0;
      req_msg  = 64'd0;
      resp_rdy = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({req_rdy, resp_val} !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_outputs: req_rdy,resp_val=%b expected 00", {req_rdy, resp_val});
      end
      n_checks++;
      if (resp_msg !== 64'd0) begin
         n_errors++;
         $display("FAIL reset_msg: resp_msg=%h expected 0", resp_msg);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (req_rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_rdy: req_rdy=%b expected 1", req_rdy);
      end
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] ta[4];
      logic [31:0] tb[4];
      logic [63:0] msg;
      logic [63:0] exp;
      int lat;
      ta[0] = 32'd100;        tb[0] = 32'd7;
      ta[1] = 32'd5;          tb[1] = 32'd0;
      ta[2] = 32'hFFFF_FFF9;  tb[2] = 32'd2;
      ta[3] = 32'h8000_0000;  tb[3] = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         send_req(ta[i], tb[i]);
         wait_resp(0, msg, lat);
         exp = ref_div(ta[i], tb[i]);
         n_checks++;
         if (msg !== exp) begin
            n_errors++;
            $display("FAIL directed_result[%0d]: %h/%h got %h expected %h", i, ta[i], tb[i], msg, exp);
         end
         n_checks++;
         if (lat !== 32) begin
            n_errors++;
            $display("FAIL directed_latency[%0d]: got %0d expected 32", i, lat);
         end
      end
      // Literal anchors independent of the model
      send_req(32'd100, 32'd7);
      wait_resp(0, msg, lat);
      n_checks++;
      if (msg !== {32'd2, 32'd14}) begin
         n_errors++;
         $display("FAIL directed_100_7: got %h expected %h", msg, {32'd2, 32'd14});
      end
      send_req(32'hFFFF_FFF9, 32'd2);
      wait_resp(0, msg, lat);
`ifdef LAB1_IMUL_INT_DIV_SIGNED_EN
      exp = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
`else
      exp = {32'd1, 32'h7FFF_FFFC};
`endif
      n_checks++;
      if (msg !== exp) begin
         n_errors++;
         $display("FAIL directed_fffffff9_2: got %h expected %h", msg, exp);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] msg;
      int lat;
      int bad;
      bad = 0;
      send_req(32'hFFFF_FFFF, 32'd1);
      resp_rdy = 1'b0;
      lat = 0;
      while (!resp_val && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      msg = resp_msg;
      n_checks++;
      if (msg !== {32'd0, 32'hFFFF_FFFF}) begin
         n_errors++;
         $display("FAIL bp_result: got %h expected %h", msg, {32'd0, 32'hFFFF_FFFF});
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp_msg !== msg || req_rdy !== 1'b0 || resp_val !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL bp_hold: %0d unstable cycles expected 0", bad);
      end
      resp_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_rdy = 1'b0;
      n_checks++;
      if ({resp_val, req_rdy} !== 2'b01) begin
         n_errors++;
         $display("FAIL bp_transfer: resp_val,req_rdy=%b expected 01", {resp_val, req_rdy});
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] msg1;
      logic [63:0] msg2;
      int lat;
      int n;
      req_val  = 1'b1;
      req_msg  = {32'd100, 32'd7};
      resp_rdy = 1'b1;
      n = 0;
      while (!req_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      req_msg = {32'd81, 32'd9};
      lat = 0;
      while (!resp_val && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      msg1 = resp_msg;
      n_checks++;
      if (msg1 !== {32'd2, 32'd14} || lat !== 32) begin
         n_errors++;
         $display("FAIL b2b_first: got %h lat %0d expected %h lat 32", msg1, lat, {32'd2, 32'd14});
      end
      n_checks++;
      if (req_rdy !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_no_accept_in_done: req_rdy=%b expected 0", req_rdy);
      end
      @(posedge clk);   // first response transfers here
      @(negedge clk);
      n_checks++;
      if ({resp_val, req_rdy} !== 2'b01) begin
         n_errors++;
         $display("FAIL b2b_idle_gap: resp_val,req_rdy=%b expected 01", {resp_val, req_rdy});
      end
      @(posedge clk);   // second request accepted here
      @(negedge clk);
      req_val = 1'b0;
      req_msg = {$urandom, $urandom};
      n_checks++;
      if (req_rdy !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_second_accept: req_rdy=%b expected 0", req_rdy);
      end
      wait_resp(0, msg2, lat);
      n_checks++;
      if (msg2 !== {32'd0, 32'd9} || lat !== 32) begin
         n_errors++;
         $display("FAIL b2b_second: got %h lat %0d expected %h lat 32", msg2, lat, {32'd0, 32'd9});
      end
   endtask

   task automatic test_reset_abort();
      logic [63:0] msg;
      int lat;
      int seen;
      send_req(32'd100, 32'd7);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({req_rdy, resp_val, resp_msg} !== 66'd0) begin
         n_errors++;
         $display("FAIL abort_reset_outputs: rdy=%b val=%b msg=%h expected 0 0 0", req_rdy, resp_val, resp_msg);
      end
      @(negedge clk);
      reset = 1'b0;
      resp_rdy = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (resp_val) seen++;
      end
      resp_rdy = 1'b0;
      n_checks++;
      if (seen != 0) begin
         n_errors++;
         $display("FAIL abort_no_resp: resp_val seen %0d cycles expected 0", seen);
      end
      send_req(32'd20, 32'd3);
      wait_resp(0, msg, lat);
      n_checks++;
      if (msg !== {32'd2, 32'd6} || lat !== 32) begin
         n_errors++;
         $display("FAIL abort_next: got %h lat %0d expected %h lat 32", msg, lat, {32'd2, 32'd6});
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] msg;
      logic [63:0] exp;
      int lat;
      int sel;
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 9);
         a   = (sel == 9) ? 32'h8000_0000 : $urandom;
         case (sel)
            0:       b = 32'd0;
            1, 2, 3: b = $urandom_range(1, 15);
            4:       b = 32'hFFFF_FFFF;
            5:       b = a >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         send_req(a, b);
         wait_resp($urandom_range(0, 3), msg, lat);
         exp = ref_div(a, b);
         n_checks++;
         if (msg !== exp || lat !== 32) begin
            n_errors++;
            $display("FAIL random[%0d]: %h/%h got %h lat %0d expected %h lat 32", i, a, b, msg, lat, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
